// File: rtl/culsans_htif_mailbox.sv
// HTIF tohost/fromhost mailbox on the SoC peripheral bus: decodes exit and
// console-putchar commands written to tohost, and queues characters for a sink.
module culsans_htif_mailbox #(
    parameter int unsigned          AddrWidth    = 64,
    parameter logic [AddrWidth-1:0] TohostAddr   = 64'h8000_1000,
    parameter logic [AddrWidth-1:0] FromhostAddr = 64'h8000_1008,
    parameter int unsigned          FifoDepth    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [63:0]          wdata_i,
    input  logic [7:0]           be_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    output logic [63:0]          rdata_o,
    output logic [31:0]          exit_o,
    output logic                 con_valid_o,
    output logic [7:0]           con_data_o,
    input  logic                 con_ready_i,
    output logic                 busy_o
);

    localparam int unsigned IdxWidth = $clog2(FifoDepth);
    localparam int unsigned PtrWidth = IdxWidth + 1;
    localparam logic [63:0] PutcharAck = 64'h0101_0000_0000_0001;

    // Bus decode
    logic tohost_sel;
    logic fromhost_sel;
    logic full_wr;
    logic exit_cmd;
    logic putchar_cmd;
    logic putchar_req;
    logic xfer;
    logic unused_addr_bits;

    // Register state
    logic [63:0] tohost_q, tohost_d;
    logic [63:0] fromhost_q, fromhost_d;
    logic [31:0] exit_q, exit_d;
    logic        rvalid_q, rvalid_d;
    logic [63:0] rdata_q, rdata_d;

    // Console FIFO state
    logic [7:0]          mem_q [FifoDepth];
    logic [7:0]          mem_d [FifoDepth];
    logic [PtrWidth-1:0] wptr_q, wptr_d;
    logic [PtrWidth-1:0] rptr_q, rptr_d;
    logic                fifo_empty;
    logic                fifo_full;
    logic                push;
    logic                pop;

    function automatic logic [63:0] merge_be(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  be);
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign unused_addr_bits = ^addr_i[2:0];

    assign tohost_sel   = (addr_i[AddrWidth-1:3] == TohostAddr[AddrWidth-1:3]);
    assign fromhost_sel = (addr_i[AddrWidth-1:3] == FromhostAddr[AddrWidth-1:3]);
    assign full_wr      = (be_i == 8'hFF);
    assign exit_cmd     = (wdata_i[63:56] == 8'h00) && wdata_i[0];
    assign putchar_cmd  = (wdata_i[63:56] == 8'h01) && (wdata_i[55:48] == 8'h01);
    assign putchar_req  = req_i && we_i && tohost_sel && full_wr && putchar_cmd;

    // The stall looks only at the registered full flag, so a pop in the
    // same cycle cannot release it; this keeps gnt_o free of con_ready_i.
    assign gnt_o = req_i && !(putchar_req && fifo_full);
    assign xfer  = req_i && gnt_o;

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[IdxWidth] != rptr_q[IdxWidth]) &&
                        (wptr_q[IdxWidth-1:0] == rptr_q[IdxWidth-1:0]);
    assign pop        = !fifo_empty && con_ready_i;

    always_comb begin
        tohost_d   = tohost_q;
        fromhost_d = fromhost_q;
        exit_d     = exit_q;
        push       = 1'b0;
        if (xfer && we_i && tohost_sel) begin
            if (full_wr && exit_cmd) begin
                tohost_d = '0;
                if (!exit_q[0]) begin
                    exit_d = wdata_i[31:0];
                end
            end else if (full_wr && putchar_cmd) begin
                push       = 1'b1;
                tohost_d   = '0;
                fromhost_d = PutcharAck;
            end else begin
                tohost_d = merge_be(tohost_q, wdata_i, be_i);
            end
        end else if (xfer && we_i && fromhost_sel) begin
            fromhost_d = merge_be(fromhost_q, wdata_i, be_i);
        end
    end

    // Reads return the pre-write register contents; writes respond with 0.
    always_comb begin
        rvalid_d = xfer;
        rdata_d  = '0;
        if (xfer && !we_i) begin
            if (tohost_sel) begin
                rdata_d = tohost_q;
            end else if (fromhost_sel) begin
                rdata_d = fromhost_q;
            end
        end
    end

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q + PtrWidth'(push);
        rptr_d = rptr_q + PtrWidth'(pop);
        if (push) begin
            mem_d[wptr_q[IdxWidth-1:0]] = wdata_i[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tohost_q   <= '0;
            fromhost_q <= '0;
            exit_q     <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            for (int i = 0; i < FifoDepth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            tohost_q   <= tohost_d;
            fromhost_q <= fromhost_d;
            exit_q     <= exit_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            mem_q      <= mem_d;
        end
    end

    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign exit_o      = exit_q;
    assign con_valid_o = !fifo_empty;
    assign con_data_o  = mem_q[rptr_q[IdxWidth-1:0]];
    assign busy_o      = !fifo_empty;

endmodule

// File: tb/tb_culsans_htif_mailbox.sv
// Directed bench for culsans_htif_mailbox: a vector table of bus transactions
// plus hand-written sequences for exit, putchar, FIFO back-pressure and reset.
module tb_culsans_htif_mailbox;

    localparam logic [63:0] TOHOST   = 64'h8000_1000;
    localparam logic [63:0] FROMHOST = 64'h8000_1008;
    localparam logic [63:0] UNMAPPED = 64'h8000_2000;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic [7:0]  be_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [63:0] rdata_o;
    logic [31:0] exit_o;
    logic        con_valid_o;
    logic [7:0]  con_data_o;
    logic        con_ready_i;
    logic        busy_o;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    typedef struct {
        bit          do_rst;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic [63:0] exp_rdata;
        logic [31:0] exp_exit;
        string       name;
    } vec_t;

    vec_t vecs[$];

    culsans_htif_mailbox dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .be_i        (be_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .exit_o      (exit_o),
        .con_valid_o (con_valid_o),
        .con_data_o  (con_data_o),
        .con_ready_i (con_ready_i),
        .busy_o      (busy_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // character sink monitor
    always @(negedge clk) begin
        if (rst && con_valid_o && con_ready_i) begin
            got_q.push_back(con_data_o);
        end
    end

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic do_reset();
        req_i   = 1'b0;
        we_i    = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
        be_i    = '0;
        rst     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Entered and left at posedge+1; returns the response data.
    task automatic bus_op(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                          input logic [7:0] be, output logic [63:0] rd);
        int n;
        n       = 0;
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        wdata_i = wd;
        be_i    = be;
        #1;
        while (!gnt_o && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check1("bus_grant", gnt_o, 1'b1);
        @(posedge clk);
        #1;
        req_i = 1'b0;
        we_i  = 1'b0;
        check1("bus_rvalid", rvalid_o, 1'b1);
        rd = rdata_o;
    endtask

    task automatic add_vec(input bit r, input bit we, input logic [63:0] a, input logic [63:0] wd,
                           input logic [7:0] be, input logic [63:0] er, input logic [31:0] ee,
                           input string nm);
        vec_t v;
        v.do_rst    = r;
        v.we        = we;
        v.addr      = a;
        v.wdata     = wd;
        v.be        = be;
        v.exp_rdata = er;
        v.exp_exit  = ee;
        v.name      = nm;
        vecs.push_back(v);
    endtask

    initial begin
        logic [63:0] rd;
        logic [7:0]  ch;
        int          n;

        rst         = 1'b0;
        req_i       = 1'b0;
        we_i        = 1'b0;
        addr_i      = '0;
        wdata_i     = '0;
        be_i        = '0;
        con_ready_i = 1'b0;

        // stimulus table
        add_vec(1, 0, TOHOST,     64'h0,                   8'hFF, 64'h0,                   32'h0, "rd_tohost_reset");
        add_vec(0, 1, TOHOST,     64'h1,                   8'h0F, 64'h0,                   32'h0, "partial_exit_wr");
        add_vec(0, 0, TOHOST,     64'h0,                   8'hFF, 64'h1,                   32'h0, "partial_exit_rd");
        add_vec(0, 1, TOHOST,     64'h3,                   8'hFF, 64'h0,                   32'h3, "full_exit3_wr");
        add_vec(0, 0, TOHOST,     64'h0,                   8'hFF, 64'h0,                   32'h3, "exit3_clears_tohost");
        add_vec(1, 1, TOHOST,     64'h7,                   8'hFF, 64'h0,                   32'h7, "exit7_wr");
        add_vec(0, 1, TOHOST,     64'h1,                   8'hFF, 64'h0,                   32'h7, "exit_sticky_wr");
        add_vec(0, 0, TOHOST,     64'h0,                   8'hFF, 64'h0,                   32'h7, "exit_sticky_tohost");
        add_vec(0, 1, TOHOST,     64'h0000_0000_8000_4000, 8'hFF, 64'h0,                   32'h7, "syscall_ptr_wr");
        add_vec(0, 0, TOHOST + 5, 64'h0,                   8'hFF, 64'h0000_0000_8000_4000, 32'h7, "syscall_ptr_rd_lowbits");
        add_vec(0, 1, FROMHOST,   64'h1122_3344_5566_7788, 8'h0F, 64'h0,                   32'h7, "fromhost_lo_wr");
        add_vec(0, 0, FROMHOST,   64'h0,                   8'hFF, 64'h0000_0000_5566_7788, 32'h7, "fromhost_lo_rd");
        add_vec(0, 1, FROMHOST,   64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, 64'h0,                   32'h7, "fromhost_hi_wr");
        add_vec(0, 0, FROMHOST,   64'h0,                   8'hFF, 64'hFFFF_FFFF_5566_7788, 32'h7, "fromhost_hi_rd");
        add_vec(0, 1, UNMAPPED,   64'hDEAD_BEEF_0000_0001, 8'hFF, 64'h0,                   32'h7, "unmapped_wr");
        add_vec(0, 0, UNMAPPED,   64'h0,                   8'hFF, 64'h0,                   32'h7, "unmapped_rd");
        add_vec(0, 0, TOHOST,     64'h0,                   8'hFF, 64'h0000_0000_8000_4000, 32'h7, "tohost_after_unmapped");
        add_vec(0, 1, TOHOST,     64'h0200_0000_0000_0041, 8'hFF, 64'h0,                   32'h7, "other_dev_wr");
        add_vec(0, 0, TOHOST,     64'h0,                   8'hFF, 64'h0200_0000_0000_0041, 32'h7, "other_dev_rd");
        add_vec(0, 1, TOHOST,     64'h0101_0000_0000_0042, 8'h7F, 64'h0,                   32'h7, "partial_putchar_wr");
        add_vec(0, 0, TOHOST,     64'h0,                   8'hFF, 64'h0201_0000_0000_0042, 32'h7, "partial_putchar_rd");

        for (int k = 0; k < vecs.size(); k++) begin
            if (vecs[k].do_rst) do_reset();
            bus_op(vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].be, rd);
            check64({vecs[k].name, "_rdata"}, rd, vecs[k].exp_rdata);
            check64({vecs[k].name, "_exit"}, {32'h0, exit_o}, {32'h0, vecs[k].exp_exit});
            check1({vecs[k].name, "_busy"}, busy_o, 1'b0);
        end

        // reset values, then exit = 1 with response timing
        do_reset();
        check64("reset_exit", {32'h0, exit_o}, 64'h0);
        check1("reset_con_valid", con_valid_o, 1'b0);
        check1("reset_busy", busy_o, 1'b0);
        check1("reset_rvalid", rvalid_o, 1'b0);
        check64("reset_rdata", rdata_o, 64'h0);
        check1("idle_gnt", gnt_o, 1'b0);
        req_i = 1'b1; we_i = 1'b1; addr_i = TOHOST; wdata_i = 64'h1; be_i = 8'hFF;
        #1;
        check1("exit1_gnt", gnt_o, 1'b1);
        @(posedge clk); #1;
        req_i = 1'b0; we_i = 1'b0;
        check1("exit1_rvalid", rvalid_o, 1'b1);
        check64("exit1_rdata", rdata_o, 64'h0);
        check64("exit1_exit", {32'h0, exit_o}, 64'h1);
        @(posedge clk); #1;
        check1("exit1_rvalid_drop", rvalid_o, 1'b0);
        bus_op(1'b0, TOHOST, 64'h0, 8'hFF, rd);
        check64("exit1_tohost_rd", rd, 64'h0);

        // single putchar with a ready sink
        con_ready_i = 1'b1;
        got_q.delete();
        req_i = 1'b1; we_i = 1'b1; addr_i = TOHOST; wdata_i = 64'h0101_0000_0000_0041; be_i = 8'hFF;
        @(posedge clk); #1;
        req_i = 1'b0; we_i = 1'b0;
        check1("putc_con_valid", con_valid_o, 1'b1);
        check64("putc_con_data", {56'h0, con_data_o}, 64'h41);
        check1("putc_busy", busy_o, 1'b1);
        @(posedge clk); #1;
        check1("putc_con_valid_drop", con_valid_o, 1'b0);
        check1("putc_busy_drop", busy_o, 1'b0);
        check64("putc_sink_count", 64'(got_q.size()), 64'h1);
        if (got_q.size() > 0) check64("putc_sink_char", {56'h0, got_q[0]}, 64'h41);
        bus_op(1'b0, FROMHOST, 64'h0, 8'hFF, rd);
        check64("putc_fromhost_ack", rd, 64'h0101_0000_0000_0001);
        bus_op(1'b0, TOHOST, 64'h0, 8'hFF, rd);
        check64("putc_tohost_cleared", rd, 64'h0);
        bus_op(1'b1, FROMHOST, 64'h0, 8'hFF, rd);
        bus_op(1'b0, FROMHOST, 64'h0, 8'hFF, rd);
        check64("fromhost_sw_clear", rd, 64'h0);

        // nine back-to-back putchars against a stalled sink
        con_ready_i = 1'b0;
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 9; i++) begin
            ch = 8'h41 + 8'(i);
            exp_q.push_back(ch);
            req_i = 1'b1; we_i = 1'b1; addr_i = TOHOST; be_i = 8'hFF;
            wdata_i = {16'h0101, 40'h0, ch};
            #1;
            check1($sformatf("fill_gnt_%0d", i), gnt_o, (i < 8));
            if (i < 8) begin
                @(posedge clk); #1;
                check1($sformatf("fill_rvalid_%0d", i), rvalid_o, 1'b1);
            end
        end
        check1("full_busy", busy_o, 1'b1);
        con_ready_i = 1'b1;
        #1;
        check1("full_stall_during_pop", gnt_o, 1'b0);
        @(posedge clk); #1;
        check1("ninth_gnt_after_pop", gnt_o, 1'b1);
        @(posedge clk); #1;
        req_i = 1'b0; we_i = 1'b0;
        check1("ninth_rvalid", rvalid_o, 1'b1);
        n = 0;
        while (busy_o && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check1("drain_busy", busy_o, 1'b0);
        check64("drain_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check64($sformatf("drain_order_%0d", i), {56'h0, got_q[i]}, {56'h0, exp_q[i]});
        end

        // asynchronous reset with characters queued and a response pending
        con_ready_i = 1'b0;
        got_q.delete();
        for (int i = 0; i < 3; i++) begin
            bus_op(1'b1, TOHOST, {16'h0101, 40'h0, 8'h61 + 8'(i)}, 8'hFF, rd);
        end
        req_i = 1'b1; we_i = 1'b0; addr_i = TOHOST; be_i = 8'hFF;
        @(posedge clk); #1;
        req_i = 1'b0;
        check1("pre_rst_rvalid", rvalid_o, 1'b1);
        check1("pre_rst_busy", busy_o, 1'b1);
        check64("pre_rst_exit", {32'h0, exit_o}, 64'h1);
        #2 rst = 1'b0;
        #1;
        check1("rst_con_valid", con_valid_o, 1'b0);
        check1("rst_busy", busy_o, 1'b0);
        check64("rst_exit", {32'h0, exit_o}, 64'h0);
        check1("rst_rvalid", rvalid_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check1("post_rst_busy", busy_o, 1'b0);
        check1("post_rst_con_valid", con_valid_o, 1'b0);
        bus_op(1'b0, TOHOST, 64'h0, 8'hFF, rd);
        check64("post_rst_tohost", rd, 64'h0);
        check64("post_rst_sink_count", 64'(got_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/culsans_htif_mailbox.md
# culsans_htif_mailbox

HTIF-style tohost/fromhost mailbox on the culsans SoC memory bus, directly upstream of the top-level `exit_o` port that the simulation bench watches. It decodes software writes to the `tohost` doubleword. Exit commands drive `exit_o`. Console putchar commands go into a small FIFO that drains to a character sink, and the block acknowledges them through `fromhost`. Requests use the OBI-style req/gnt/rvalid protocol of the SoC peripheral bus.

## Interface
- `AddrWidth`, 64, request address width
- `TohostAddr`, 64'h8000_1000, byte address of `tohost` (8-byte aligned)
- `FromhostAddr`, 64'h8000_1008, byte address of `fromhost` (8-byte aligned)
- `FifoDepth`, 8, console FIFO entries (power of two, ≥2)
- `clk` in 1: clock, all state on rising edge
- `rst` in 1: reset, asynchronous, active-low
- `req_i` in 1: bus request
- `we_i` in 1: 1 = write, 0 = read
- `addr_i` in AddrWidth: byte address; bits [2:0] ignored
- `wdata_i` in 64: write data
- `be_i` in 8: byte enables
- `gnt_o` out 1: request accepted this cycle
- `rvalid_o` out 1: response valid
- `rdata_o` out 64: read data, valid with `rvalid_o`
- `exit_o` out 32: exit word; bit 0 = done, [31:1] = return code
- `con_valid_o` out 1: console character available
- `con_data_o` out 8: console character
- `con_ready_i` in 1: sink accepts character
- `busy_o` out 1: FIFO non-empty

## Operation
- Address match compares `addr_i[AddrWidth-1:3]`. Unmatched addresses are granted; their writes are dropped and their reads return 0.
- `gnt_o = req_i`, except that a full-width putchar write to `tohost` while the FIFO is full holds `gnt_o = 0` until the FIFO is not full. Full is the registered state: a pop in the same cycle does not release the stall.
- Writes merge into the target register per `be_i`.
- A command is decoded only on a `tohost` write with `be_i == 8'hFF`. Fields of the write data `v`: `dev = v[63:56]`, `cmd = v[55:48]`.
- Exit command, when `dev == 0` and `v[0] == 1`:
  - `exit_o <= v[31:0]` if `exit_o[0] == 0`; otherwise `exit_o` is unchanged (sticky, first exit wins).
  - `tohost <= 0`.
- Putchar command, when `dev == 1` and `cmd == 1`:
  - Push `v[7:0]` into the FIFO.
  - `tohost <= 0`.
  - `fromhost <= 64'h0101_0000_0000_0001`.
- Any other full-width value, including a syscall pointer (`dev == 0`, `v[0] == 0`), is stored in `tohost` with no side effect.
- Software writes to `fromhost` merge per `be_i`. No hardware/software collision is possible, because only one request is granted per cycle.
- Console FIFO:
  - `con_valid_o` = not empty; `con_data_o` = head entry.
  - Pop on `con_valid_o && con_ready_i`.
  - Push and pop in the same cycle are both legal when not full.
  - Pointers are `$clog2(FifoDepth)+1` bits wide; full and empty are decoded from the MSB and equality; pointers wrap modulo 2·depth.
  - Order is preserved.
- `busy_o` = not empty.

## Timing
- Reset values: `exit_o` = 0, `tohost` = 0, `fromhost` = 0, FIFO empty, `con_valid_o` = 0, `busy_o` = 0, `rvalid_o` = 0, `rdata_o` = 0.
- `gnt_o` is combinational from `req_i` and the FIFO-full state.
- `rvalid_o` is asserted exactly one cycle after each `req_i && gnt_o`, for reads and for writes. `rdata_o` is 0 for writes.
- A read returns the register value before any write granted in the same cycle. Back-to-back requests are sustained at one per cycle.
- Register updates are visible to the cycle after the grant: the next read, and `exit_o`.
- Putchar latency: `con_valid_o` rises the cycle after the grant edge when the FIFO was empty.
- `rst` assertion takes effect immediately on all state and outputs, including mid-FIFO and mid-response. Any pending `rvalid_o` is dropped.

## Test plan
- Write `tohost = 64'h1`, `be = FF` -> one cycle later `exit_o = 32'h1`; a subsequent read of `tohost` returns 0; `rvalid_o` is asserted one cycle after each grant.
- Write `tohost = 64'h0101_0000_0000_0041` with `con_ready_i = 1` -> `con_valid_o` for exactly 1 cycle with `con_data_o = 8'h41`; a read of `fromhost` returns `64'h0101_0000_0000_0001`; software write 0 to `fromhost` -> reads 0.
- Hold `con_ready_i = 0` and issue 9 putchars `'A'..'I'` back-to-back -> the first 8 are granted and the 9th sees `gnt_o = 0`. Raise `con_ready_i` -> the 9th is granted the cycle after the first pop; the sink receives `A..I` in order.
- Write `tohost = 64'h7` then `64'h1` -> `exit_o = 32'h7` and stays 7; the second write leaves `tohost = 0`.
- Partial write `tohost = 64'h1` with `be = 8'h0F` -> `exit_o` stays 0 and a read of `tohost` returns 1; then a full write of `64'h3` -> `exit_o = 32'h3`.
- With 3 characters queued and `con_ready_i = 0`, assert `rst` mid-cycle -> `con_valid_o`, `busy_o`, and `exit_o` go to 0 immediately; after release, the FIFO is empty and a read of `tohost` returns 0.
